// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline advance controller.
// Holds the FSM state encoding, the flush NOP and the handshake legality rule.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'd4;

   // A stall must freeze both PC and IF/ID; a clean cycle must advance both.
   // A taken branch overrides everything, so that cycle is never checked.
   function automatic logic hs_violation(input logic stall,
                                         input logic pcwrite,
                                         input logic if_id_write,
                                         input logic branch_taken);
      logic viol;
      viol = 1'b0;
      if (!branch_taken) begin
         if (stall)
            viol = pcwrite | if_id_write;
         else
            viol = ~(pcwrite & if_id_write);
      end
      return viol;
   endfunction

endpackage

// File: rtl/pipe_advance_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the debug
// stall and flush counters.
module sat_counter
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      return (&val) ? val : val + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= sat_inc(count);
   end

endmodule

// File: rtl/pipe_advance_ctrl.sv
// PC, IF/ID latch and ID/EX bubble mux driven by the hazard unit strobes and
// branch flush, with handshake monitoring and debug stall/flush counters.
module pipe_advance_ctrl
   import pipe_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter int          CTRL_W    = 10,
   parameter int          MAX_STALL = 2,
   parameter int          CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              pcwrite,
   input  logic              if_id_write,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       instr_in,
   input  logic [CTRL_W-1:0] id_ctrl_in,
   output logic [31:0]       pc,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic [CTRL_W-1:0] id_ex_ctrl,
   output logic              id_ex_valid,
   output logic              hs_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int               RUN_W       = $clog2(MAX_STALL + 2);
   localparam logic [RUN_W-1:0] STALL_LIMIT = RUN_W'(MAX_STALL + 1);

   state_t           state;
   logic [RUN_W-1:0] stall_run;
   logic [RUN_W-1:0] run_next;
   logic [31:0]      pc_plus4;
   logic             stall_eff;
   logic             viol;

   assign pc_plus4  = pc + PC_STEP;
   assign stall_eff = stall & ~branch_taken;
   assign viol      = hs_violation(stall, pcwrite, if_id_write, branch_taken);

   // Run length saturates at the limit so it cannot wrap back into range.
   always_comb begin
      run_next = '0;
      if (stall_eff)
         run_next = (stall_run == STALL_LIMIT) ? stall_run : stall_run + 1'b1;
   end

   // Fetch stage: PC register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc <= PC_RESET;
      else if (branch_taken)
         pc <= branch_target;
      else if (pcwrite)
         pc <= pc_plus4;
   end

   // IF/ID boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (branch_taken) begin
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else if (if_id_write) begin
         if_id_instr <= instr_in;
         if_id_pc4   <= pc_plus4;
         if_id_valid <= 1'b1;
      end
   end

   // ID/EX boundary: bubble on flush or stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_ctrl  <= '0;
         id_ex_valid <= 1'b0;
      end else if (branch_taken || stall) begin
         id_ex_ctrl  <= '0;
         id_ex_valid <= 1'b0;
      end else begin
         id_ex_ctrl  <= id_ctrl_in;
         id_ex_valid <= if_id_valid;
      end
   end

   // Monitor only: ERR never gates the datapath, it just latches the report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         stall_run <= '0;
         hs_err    <= 1'b0;
      end else begin
         stall_run <= run_next;
         case (state)
            ERR: begin
               state  <= ERR;
               hs_err <= 1'b1;
            end
            default: begin
               if (viol || run_next == STALL_LIMIT) begin
                  state  <= ERR;
                  hs_err <= 1'b1;
               end else if (stall_eff) begin
                  state  <= HOLD;
                  hs_err <= 1'b0;
               end else begin
                  state  <= RUN;
                  hs_err <= 1'b0;
               end
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_eff),
      .clr   (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (branch_taken),
      .clr   (1'b0),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_advance_ctrl.sv
// Directed bench for pipe_advance_ctrl: hand-computed expectations checked
// with immediate assertions after each rising edge.
module tb_pipe_advance_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        pcwrite;
   logic        if_id_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] instr_in;
   logic [9:0]  id_ctrl_in;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [9:0]  id_ex_ctrl;
   logic        id_ex_valid;
   logic        hs_err;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int checks;
   int failures;

   pipe_advance_ctrl #(
      .PC_RESET  (32'h0000_0000),
      .CTRL_W    (10),
      .MAX_STALL (2),
      .CNT_W     (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .pcwrite       (pcwrite),
      .if_id_write   (if_id_write),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .id_ctrl_in    (id_ctrl_in),
      .pc            (pc),
      .if_id_instr   (if_id_instr),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .id_ex_ctrl    (id_ex_ctrl),
      .id_ex_valid   (id_ex_valid),
      .hs_err        (hs_err),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   // Instruction memory stand-in: the word at address a is 32'hA000_0000 | a.
   assign instr_in = 32'hA000_0000 | pc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic s, input logic pw, input logic iw,
                       input logic bt, input logic [31:0] tgt, input logic [9:0] ctrl);
      stall         = s;
      pcwrite       = pw;
      if_id_write   = iw;
      branch_taken  = bt;
      branch_target = tgt;
      id_ctrl_in    = ctrl;
      @(posedge clk);
      #1;
   endtask

   task automatic run_ok(input logic [9:0] ctrl);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, ctrl);
   endtask

   task automatic stall_ok();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 10'h3FF);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      stall         = 1'b0;
      pcwrite       = 1'b1;
      if_id_write   = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      id_ctrl_in    = 10'h0;

      // Reset held across edges
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pc",        pc, 32'h0);
      chk("rst_ifid_v",    32'(if_id_valid), 32'h0);
      chk("rst_ifid_ins",  if_id_instr, 32'h0);
      chk("rst_idex_v",    32'(id_ex_valid), 32'h0);
      chk("rst_idex_ctrl", 32'(id_ex_ctrl), 32'h0);
      chk("rst_hs_err",    32'(hs_err), 32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Normal advance
      run_ok(10'h155);
      chk("e1_pc",       pc, 32'h4);
      chk("e1_ins",      if_id_instr, 32'hA000_0000);
      chk("e1_pc4",      if_id_pc4, 32'h4);
      chk("e1_ifid_v",   32'(if_id_valid), 32'h1);
      chk("e1_idex_v",   32'(id_ex_valid), 32'h0);
      chk("e1_ctrl",     32'(id_ex_ctrl), 32'h155);
      run_ok(10'h155);
      chk("e2_pc",       pc, 32'h8);
      chk("e2_pc4",      if_id_pc4, 32'h8);
      chk("e2_idex_v",   32'(id_ex_valid), 32'h1);

      // One-cycle load-use stall at pc=8
      stall_ok();
      chk("st_pc",       pc, 32'h8);
      chk("st_ins",      if_id_instr, 32'hA000_0004);
      chk("st_pc4",      if_id_pc4, 32'h8);
      chk("st_ctrl",     32'(id_ex_ctrl), 32'h0);
      chk("st_idex_v",   32'(id_ex_valid), 32'h0);
      chk("st_cnt",      32'(stall_cnt), 32'h1);
      chk("st_hs_err",   32'(hs_err), 32'h0);
      run_ok(10'h2AA);
      chk("e4_pc",       pc, 32'hC);
      chk("e4_ins",      if_id_instr, 32'hA000_0008);
      chk("e4_pc4",      if_id_pc4, 32'hC);
      chk("e4_ctrl",     32'(id_ex_ctrl), 32'h2AA);
      chk("e4_idex_v",   32'(id_ex_valid), 32'h1);
      run_ok(10'h2AA);
      chk("e5_pc",       pc, 32'h10);

      // Branch with simultaneous stall: flush wins, not counted as stall
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 10'h3FF);
      chk("br_pc",       pc, 32'h40);
      chk("br_ifid_v",   32'(if_id_valid), 32'h0);
      chk("br_ins",      if_id_instr, 32'h0);
      chk("br_pc4",      if_id_pc4, 32'h0);
      chk("br_idex_v",   32'(id_ex_valid), 32'h0);
      chk("br_flush",    32'(flush_cnt), 32'h1);
      chk("br_stall",    32'(stall_cnt), 32'h1);
      chk("br_hs_err",   32'(hs_err), 32'h0);
      run_ok(10'h011);
      chk("ab1_pc",      pc, 32'h44);
      chk("ab1_pc4",     if_id_pc4, 32'h44);
      chk("ab1_ifid_v",  32'(if_id_valid), 32'h1);
      chk("ab1_idex_v",  32'(id_ex_valid), 32'h0);
      run_ok(10'h011);
      chk("ab2_idex_v",  32'(id_ex_valid), 32'h1);

      // Two consecutive stalls: MAX_STALL exactly, still legal
      stall_ok();
      stall_ok();
      chk("s2_pc",       pc, 32'h48);
      chk("s2_hs_err",   32'(hs_err), 32'h0);
      chk("s2_cnt",      32'(stall_cnt), 32'h3);
      run_ok(10'h011);
      chk("s2r_pc",      pc, 32'h4C);

      // Three consecutive stalls: error on the third stalled edge
      stall_ok();
      stall_ok();
      chk("s3b_hs_err",  32'(hs_err), 32'h0);
      chk("s3b_pc",      pc, 32'h4C);
      stall_ok();
      chk("s3c_hs_err",  32'(hs_err), 32'h1);
      chk("s3c_pc",      pc, 32'h4C);
      chk("s3c_cnt",     32'(stall_cnt), 32'h6);

      // stall with pcwrite: error is sticky, datapath still obeys pcwrite
      do_reset();
      chk("r2_hs_err",   32'(hs_err), 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 10'h0);
      chk("v1_hs_err",   32'(hs_err), 32'h1);
      chk("v1_pc",       pc, 32'h4);
      for (int i = 0; i < 10; i++) begin
         run_ok(10'h001);
         chk("v1_sticky", 32'(hs_err), 32'h1);
      end
      chk("v1_pc_end",   pc, 32'h2C);

      // Clean cycle without pcwrite is also illegal
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 10'h0);
      chk("v2_hs_err",   32'(hs_err), 32'h1);
      chk("v2_pc",       pc, 32'h0);

      // PC wrap and async reset in the middle of a stall
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 10'h0);
      chk("w_pc_top",    pc, 32'hFFFF_FFFC);
      run_ok(10'h0F0);
      chk("w_pc_wrap",   pc, 32'h0);
      chk("w_pc4",       if_id_pc4, 32'h0);
      chk("w_ins",       if_id_instr, 32'hFFFF_FFFC);
      run_ok(10'h0F0);
      stall_ok();
      chk("w_st_pc",     pc, 32'h4);
      chk("w_st_cnt",    32'(stall_cnt), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_pc",       pc, 32'h0);
      chk("ar_ifid_v",   32'(if_id_valid), 32'h0);
      chk("ar_ins",      if_id_instr, 32'h0);
      chk("ar_pc4",      if_id_pc4, 32'h0);
      chk("ar_idex_v",   32'(id_ex_valid), 32'h0);
      chk("ar_ctrl",     32'(id_ex_ctrl), 32'h0);
      chk("ar_stall",    32'(stall_cnt), 32'h0);
      chk("ar_flush",    32'(flush_cnt), 32'h0);
      chk("ar_hs_err",   32'(hs_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_ok(10'h0F0);
      chk("ar1_pc",      pc, 32'h4);
      chk("ar1_ins",     if_id_instr, 32'hA000_0000);
      chk("ar1_pc4",     if_id_pc4, 32'h4);
      chk("ar1_hs_err",  32'(hs_err), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_advance_ctrl.md
# pipe_advance_ctrl

Consumer side of the load-use hazard handshake: holds the PC register, the IF/ID latch and the ID/EX control bubble mux, and applies the `stall`, `pcwrite` and `if_id_write` strobes issued by the hazard detection unit, plus the branch-taken flush. Sits between instruction fetch, the decoder and the ID/EX register in the 5-stage MIPS-32 pipeline. Also checks handshake consistency, bounds stall length and keeps saturating stall/flush counters for debug.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset
- `CTRL_W`, 10, width of the decoded control bundle passed to ID/EX
- `MAX_STALL`, 2, maximum legal consecutive stall cycles
- `CNT_W`, 16, width of the debug counters

Ports (all outputs registered):
- `clk` input 1: rising-edge clock
- `rst` input 1: asynchronous, active-high reset
- `stall` input 1: insert bubble into ID/EX
- `pcwrite` input 1: PC may advance
- `if_id_write` input 1: IF/ID may load
- `branch_taken` input 1: branch resolved taken this cycle
- `branch_target` input 32: redirect address
- `instr_in` input 32: instruction memory output for current `pc`
- `id_ctrl_in` input CTRL_W: decoder control for the instruction in IF/ID
- `pc` output 32: fetch address
- `if_id_instr` output 32: latched instruction
- `if_id_pc4` output 32: latched PC+4
- `if_id_valid` output 1: IF/ID holds a real instruction
- `id_ex_ctrl` output CTRL_W: control into EX, zero when bubbled
- `id_ex_valid` output 1: EX holds a real instruction
- `hs_err` output 1: sticky protocol error
- `stall_cnt` output CNT_W: saturating count of bubbled cycles
- `flush_cnt` output CNT_W: saturating count of branch flushes

## Operation
- Priority per cycle: `branch_taken` > `stall` > normal advance.
- PC: branch_taken → `branch_target`; else pcwrite=1 → `pc+4` (mod 2^32, wraps); else hold.
- IF/ID: branch_taken → instr=NOP (32'h0), pc4=0, valid=0; else if_id_write=1 → `instr_in`, `pc+4`, valid=1; else hold all three.
- ID/EX: branch_taken or stall=1 → ctrl=0, valid=0; else ctrl=`id_ctrl_in`, valid=`if_id_valid`.
- Handshake legality: when stall=1, pcwrite and if_id_write must both be 0; when stall=0 and branch_taken=0, both must be 1. Any violation sets `hs_err`.
- FSM states RUN, HOLD, ERR:
  - RUN → HOLD on stall=1 and branch_taken=0. HOLD → RUN on stall=0 or branch_taken=1.
  - Consecutive-stall counter clears in RUN and increments per HOLD cycle; reaching MAX_STALL+1 → ERR.
  - Any handshake violation → ERR from any state. ERR is sticky until `rst`; `hs_err`=1 in ERR only.
  - Datapath keeps obeying inputs in ERR; the error is reported only, never enforced.
- `stall_cnt` increments every cycle stall=1 and branch_taken=0. `flush_cnt` increments every cycle branch_taken=1. Both saturate at all-ones.

## Timing
- Reset (async, immediate): pc=PC_RESET; if_id_instr=0, if_id_pc4=0, if_id_valid=0; id_ex_ctrl=0, id_ex_valid=0; hs_err=0; both counters 0; FSM=RUN.
- All updates take effect on the rising edge after the inputs are sampled. One cycle latency from any strobe to its effect.
- A one-cycle load-use stall produces exactly one ID/EX bubble. PC and IF/ID hold for exactly that cycle.
- Simultaneous branch_taken and stall: flush applies and the stall is ignored. Not counted in `stall_cnt`. No handshake check that cycle.
- Reset mid-stall: pipeline returns to PC_RESET with both latches invalid. The next cycle after release fetches from PC_RESET.

## Structure
- Shared package `pipe_pkg`: FSM state enum (RUN/HOLD/ERR), `NOP_INSTR`=32'h0, `PC_STEP`=4.
- One sub-module `sat_counter` (parameter CNT_W, inputs `inc` and `clr`), instantiated twice for the debug counters.

## Test plan
- Reset release, no hazards, 4 cycles → pc 0,4,8,12,16; if_id_pc4 follows one cycle later; id_ex_valid=1 from cycle 2.
- Load-use stall for 1 cycle at pc=8 (stall=1, pcwrite=0, if_id_write=0) → pc holds 8, IF/ID holds, id_ex_ctrl=0/valid=0 for one cycle, stall_cnt=1, hs_err=0.
- branch_taken=1, target 32'h40, with stall=1 in the same cycle → pc=32'h40, if_id_valid=0, id_ex_valid=0, flush_cnt=1, stall_cnt unchanged.
- stall=1 with pcwrite=1 → hs_err=1 next edge and stays 1 through 10 further clean cycles until `rst`.
- stall held 3 consecutive cycles with MAX_STALL=2 → hs_err rises on the third stalled edge. PC held throughout.
- pc=32'hFFFF_FFFC with pcwrite=1 → pc=0; `rst` asserted mid-stall → all outputs at reset values asynchronously.
